// File: rtl/maze_step_scheduler_pkg.sv
// Shared types and defaults for the maze step scheduler.
// Optional drop counter: define MAZE_STEP_DROP_COUNT_EN.
package maze_step_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ERASE  = 3'd1,
    S_SETTLE = 3'd2,
    S_UPDATE = 3'd3,
    S_DRAW   = 3'd4
  } state_e;

  localparam int unsigned DEF_TICK_RELOAD   = 6_249_999;
  localparam int unsigned DEF_SETTLE_CYCLES = 2;
  localparam int unsigned DROP_W            = 8;

endpackage

// File: rtl/maze_step_scheduler_if.sv
// Erase/draw engine handshake and position-commit strobe.
// master = scheduler, slave = engines and game logic.
interface maze_step_scheduler_if;

  logic erase_req;
  logic erase_done;
  logic draw_req;
  logic draw_done;
  logic update_pos;

  modport master (
    output erase_req,
    output draw_req,
    output update_pos,
    input  erase_done,
    input  draw_done
  );

  modport slave (
    input  erase_req,
    input  draw_req,
    input  update_pos,
    output erase_done,
    output draw_done
  );

endinterface

// File: rtl/maze_step_scheduler_step_tick_gen.sv
// Countdown tick generator: one-cycle tick every TICK_RELOAD+1
// cycles while run is high; held at reload while run is low.
module step_tick_gen
  import maze_step_scheduler_pkg::*;
#(
  parameter int unsigned TICK_W      = 23,
  parameter int unsigned TICK_RELOAD = DEF_TICK_RELOAD
) (
  input  logic clock,
  input  logic resetn,
  input  logic run,
  output logic tick
);

  localparam logic [TICK_W-1:0] RELOAD = TICK_W'(TICK_RELOAD);

  logic [TICK_W-1:0] cnt_q;
  logic [TICK_W-1:0] cnt_d;

  assign tick = run && (cnt_q == '0);

  always_comb begin
    cnt_d = RELOAD;
    if (run && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (resetn) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/maze_step_scheduler.sv
// Per-tick game step: erase sprite, settle, commit position, redraw.
// Optional drop counter: define MAZE_STEP_DROP_COUNT_EN.
module maze_step_scheduler
  import maze_step_scheduler_pkg::*;
#(
  parameter int unsigned TICK_W        = 23,
  parameter int unsigned TICK_RELOAD   = DEF_TICK_RELOAD,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned STEP_W        = 16
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  run,
  input  logic                  clear_overrun,
  maze_step_scheduler_if.master eng,
  output logic                  busy,
  output logic                  tick,
  output logic                  overrun,
  output logic [STEP_W-1:0]     step_count,
  output logic [DROP_W-1:0]     drop_count
);

  localparam int unsigned SC_W =
    (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;

  state_e            state_q, state_d;
  logic              erase_req_q, erase_req_d;
  logic              draw_req_q, draw_req_d;
  logic              update_pos_q, update_pos_d;
  logic              overrun_q, overrun_d;
  logic [SC_W-1:0]   settle_q, settle_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              dropped;
  logic              settle_last;

  step_tick_gen #(
    .TICK_W      (TICK_W),
    .TICK_RELOAD (TICK_RELOAD)
  ) u_tick (
    .clock  (clock),
    .resetn (resetn),
    .run    (run),
    .tick   (tick)
  );

  // Ticks are never queued: any tick outside IDLE is lost.
  assign dropped     = tick && (state_q != S_IDLE);
  assign settle_last = (32'(settle_q) + 32'd1) >= SETTLE_CYCLES;

  always_comb begin
    state_d      = state_q;
    erase_req_d  = erase_req_q;
    draw_req_d   = draw_req_q;
    update_pos_d = 1'b0;
    settle_d     = settle_q;
    step_d       = step_q;
    overrun_d    = overrun_q;
    if (clear_overrun) begin
      overrun_d = 1'b0;
    end
    if (dropped) begin
      overrun_d = 1'b1;
    end
    unique case (state_q)
      S_IDLE: begin
        if (tick) begin
          state_d     = S_ERASE;
          erase_req_d = 1'b1;
        end
      end
      S_ERASE: begin
        if (eng.erase_done) begin
          erase_req_d = 1'b0;
          settle_d    = '0;
          if (SETTLE_CYCLES == 0) begin
            state_d      = S_UPDATE;
            update_pos_d = 1'b1;
          end else begin
            state_d = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        if (settle_last) begin
          state_d      = S_UPDATE;
          update_pos_d = 1'b1;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      S_UPDATE: begin
        state_d    = S_DRAW;
        draw_req_d = 1'b1;
      end
      S_DRAW: begin
        if (eng.draw_done) begin
          state_d    = S_IDLE;
          draw_req_d = 1'b0;
          step_d     = step_q + 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        erase_req_d = 1'b0;
        draw_req_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (resetn) begin
      state_q      <= S_IDLE;
      erase_req_q  <= 1'b0;
      draw_req_q   <= 1'b0;
      update_pos_q <= 1'b0;
      overrun_q    <= 1'b0;
      settle_q     <= '0;
      step_q       <= '0;
    end else begin
      state_q      <= state_d;
      erase_req_q  <= erase_req_d;
      draw_req_q   <= draw_req_d;
      update_pos_q <= update_pos_d;
      overrun_q    <= overrun_d;
      settle_q     <= settle_d;
      step_q       <= step_d;
    end
  end

`ifdef MAZE_STEP_DROP_COUNT_EN
  logic [DROP_W-1:0] drop_q, drop_d;

  // A drop in the same cycle as a clear leaves a count of one.
  always_comb begin
    drop_d = drop_q;
    if (clear_overrun) begin
      drop_d = '0;
    end
    if (dropped) begin
      if (clear_overrun) begin
        drop_d = DROP_W'(1);
      end else if (drop_q != '1) begin
        drop_d = drop_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (resetn) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_count = drop_q;
`else
  assign drop_count = '0;
`endif

  assign busy           = (state_q != S_IDLE);
  assign overrun        = overrun_q;
  assign step_count     = step_q;
  assign eng.erase_req  = erase_req_q;
  assign eng.draw_req   = draw_req_q;
  assign eng.update_pos = update_pos_q;

endmodule

// File: tb/tb_maze_step_scheduler.sv
// Scoreboard bench: dut0 (SETTLE_CYCLES=2, scripted engines) and
// dut1 (SETTLE_CYCLES=0, engines answer immediately).
module tb_maze_step_scheduler;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        run = 1'b0;
  logic        run1 = 1'b0;
  logic        clear_overrun = 1'b0;
  logic        busy, tick, overrun;
  logic [15:0] step_count;
  logic [7:0]  drop_count;
  logic        busy1, tick1, overrun1;
  logic [15:0] step_count1;
  logic [7:0]  drop_count1;

  maze_step_scheduler_if bus0 ();
  maze_step_scheduler_if bus1 ();

  maze_step_scheduler #(
    .TICK_W(23), .TICK_RELOAD(9), .SETTLE_CYCLES(2), .STEP_W(16)
  ) dut0 (
    .clock(clk), .resetn(resetn), .run(run),
    .clear_overrun(clear_overrun), .eng(bus0),
    .busy(busy), .tick(tick), .overrun(overrun),
    .step_count(step_count), .drop_count(drop_count)
  );

  maze_step_scheduler #(
    .TICK_W(23), .TICK_RELOAD(9), .SETTLE_CYCLES(0), .STEP_W(16)
  ) dut1 (
    .clock(clk), .resetn(resetn), .run(run1),
    .clear_overrun(1'b0), .eng(bus1),
    .busy(busy1), .tick(tick1), .overrun(overrun1),
    .step_count(step_count1), .drop_count(drop_count1)
  );

  assign bus1.erase_done = bus1.erase_req;
  assign bus1.draw_done  = bus1.draw_req;

  always #5 clk = ~clk;

  typedef struct {
    int    cyc;
    string name;
    int    exp;
  } chk_t;

  chk_t  pq[$];
  int    evq[4][$];
  string evn[4] = '{"tick", "update_pos", "tick1", "update_pos1"};
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int dc(int v);
`ifdef MAZE_STEP_DROP_COUNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  function automatic int act(string n);
    case (n)
      "busy":       return int'(busy);
      "tick":       return int'(tick);
      "overrun":    return int'(overrun);
      "step":       return int'(step_count);
      "drop":       return int'(drop_count);
      "erase_req":  return int'(bus0.erase_req);
      "draw_req":   return int'(bus0.draw_req);
      "update_pos": return int'(bus0.update_pos);
      "erase_req1": return int'(bus1.erase_req);
      "busy1":      return int'(busy1);
      "overrun1":   return int'(overrun1);
      "step1":      return int'(step_count1);
      default:      return -1;
    endcase
  endfunction

  task automatic exp_at(int c, string n, int v);
    int i = 0;
    while (i < pq.size() && pq[i].cyc <= c) i++;
    pq.insert(i, '{cyc: c, name: n, exp: v});
  endtask

  task automatic wait_cyc(int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: point checks by cycle, pulse events in FIFO order.
  always @(negedge clk) begin
    logic [3:0] ev;
    ev = {bus1.update_pos, tick1, bus0.update_pos, tick};
    while (pq.size() > 0 && pq[0].cyc <= cyc) begin
      checks++;
      if (pq[0].cyc != cyc) begin
        errors++;
        $display("FAIL %s not sampled at cycle %0d (now %0d)",
                 pq[0].name, pq[0].cyc, cyc);
      end else if (act(pq[0].name) != pq[0].exp) begin
        errors++;
        $display("FAIL %s @%0d: got %0d, expected %0d",
                 pq[0].name, cyc, act(pq[0].name), pq[0].exp);
      end
      void'(pq.pop_front());
    end
    for (int k = 0; k < 4; k++) begin
      if (ev[k] === 1'b1) begin
        checks++;
        if (evq[k].size() == 0) begin
          errors++;
          $display("FAIL %s pulse: got cycle %0d, expected none",
                   evn[k], cyc);
        end else begin
          if (evq[k][0] != cyc) begin
            errors++;
            $display("FAIL %s pulse: got cycle %0d, expected %0d",
                     evn[k], cyc, evq[k][0]);
          end
          void'(evq[k].pop_front());
        end
      end
    end
  end

  initial begin
    bus0.erase_done = 1'b0;
    bus0.draw_done  = 1'b0;

    // reset values
    exp_at(2, "busy", 0);
    exp_at(2, "tick", 0);
    exp_at(2, "erase_req", 0);
    exp_at(2, "draw_req", 0);
    exp_at(2, "update_pos", 0);
    exp_at(2, "step", 0);
    exp_at(2, "overrun", 0);
    exp_at(2, "drop", 0);
    // dut1: no settle, done accepted in the req's first cycle
    evq[2].push_back(12);
    evq[2].push_back(22);
    evq[3].push_back(14);
    evq[3].push_back(24);
    exp_at(13, "erase_req1", 1);
    exp_at(14, "erase_req1", 0);
    exp_at(30, "step1", 2);
    exp_at(30, "overrun1", 0);
    exp_at(30, "busy1", 0);

    wait_cyc(3);
    resetn = 1'b0;
    run    = 1'b1;
    run1   = 1'b1;
    // step 1: tick 12, run off during the step
    evq[0].push_back(12);
    evq[1].push_back(19);
    exp_at(13, "erase_req", 1);
    exp_at(13, "busy", 1);
    exp_at(16, "erase_req", 1);
    exp_at(17, "erase_req", 0);
    exp_at(17, "busy", 1);
    exp_at(20, "draw_req", 1);
    exp_at(22, "tick", 0);
    exp_at(24, "draw_req", 1);
    exp_at(24, "busy", 1);
    exp_at(24, "step", 0);
    exp_at(25, "draw_req", 0);
    exp_at(25, "busy", 0);
    exp_at(25, "step", 1);
    exp_at(25, "overrun", 0);

    wait_cyc(13);
    run = 1'b0;
    wait_cyc(16);
    bus0.erase_done = 1'b1;
    wait_cyc(17);
    bus0.erase_done = 1'b0;
    wait_cyc(24);
    bus0.draw_done = 1'b1;
    wait_cyc(25);
    bus0.draw_done = 1'b0;
    run1 = 1'b0;

    wait_cyc(27);
    run = 1'b1;
    // step 2: long erase, drops at 46/56, tick 66 on draw_done
    for (int t = 36; t <= 86; t += 10) evq[0].push_back(t);
    evq[1].push_back(63);
    exp_at(47, "overrun", 1);
    exp_at(47, "drop", dc(1));
    exp_at(57, "overrun", 1);
    exp_at(57, "drop", dc(2));
    exp_at(58, "overrun", 1);
    exp_at(59, "overrun", 0);
    exp_at(59, "drop", 0);
    exp_at(59, "erase_req", 1);
    exp_at(64, "draw_req", 1);
    exp_at(67, "step", 2);
    exp_at(67, "busy", 0);
    exp_at(67, "overrun", 1);
    exp_at(67, "drop", dc(1));
    exp_at(68, "erase_req", 0);
    exp_at(68, "busy", 0);

    wait_cyc(58);
    clear_overrun = 1'b1;
    wait_cyc(59);
    clear_overrun = 1'b0;
    wait_cyc(60);
    bus0.erase_done = 1'b1;
    wait_cyc(61);
    bus0.erase_done = 1'b0;
    wait_cyc(66);
    bus0.draw_done = 1'b1;
    wait_cyc(67);
    bus0.draw_done = 1'b0;

    // step 3: clear vs drop at 86, reset mid-draw, stray dones
    evq[1].push_back(91);
    exp_at(86, "drop", dc(1));
    exp_at(87, "overrun", 1);
    exp_at(87, "drop", dc(1));
    exp_at(92, "draw_req", 1);
    exp_at(92, "step", 2);
    exp_at(95, "busy", 0);
    exp_at(95, "erase_req", 0);
    exp_at(95, "draw_req", 0);
    exp_at(95, "update_pos", 0);
    exp_at(95, "step", 0);
    exp_at(95, "overrun", 0);
    exp_at(95, "drop", 0);
    exp_at(99, "busy", 0);
    exp_at(99, "step", 0);
    exp_at(99, "erase_req", 0);
    exp_at(99, "draw_req", 0);

    wait_cyc(86);
    clear_overrun = 1'b1;
    wait_cyc(87);
    clear_overrun = 1'b0;
    wait_cyc(88);
    bus0.erase_done = 1'b1;
    wait_cyc(89);
    bus0.erase_done = 1'b0;
    wait_cyc(94);
    resetn = 1'b1;
    wait_cyc(95);
    resetn = 1'b0;
    wait_cyc(97);
    bus0.erase_done = 1'b1;
    bus0.draw_done  = 1'b1;
    wait_cyc(98);
    bus0.erase_done = 1'b0;
    bus0.draw_done  = 1'b0;
    wait_cyc(100);
    run = 1'b0;

    wait_cyc(110);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (evq[k].size() != 0) begin
        errors++;
        $display("FAIL %s pulse: got none, expected cycle %0d",
                 evn[k], evq[k][0]);
      end
    end
    checks++;
    if (pq.size() != 0) begin
      errors++;
      $display("FAIL pending checks: got %0d left, expected 0",
               pq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
